// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for a common-anode multi-digit
// 7-segment display. It provides a per-slot blank interval, PWM brightness,
// per-digit enable and decimal point, and leading-zero suppression. Display
// data is double-buffered and applied only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 32768,
    parameter int BLANK_CYCLES = 256,
    parameter int BRIGHT_W     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_lz_blank,
    input  logic [BRIGHT_W-1:0]     i_brightness,
    input  logic                    i_load,
    output logic                    o_pending,
    output logic                    o_frame_done,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    // Length of one brightness step in cycles; ON_LEN = STEP * (brightness + 1).
    localparam int STEP  = (DIGIT_CYCLES - BLANK_CYCLES) / (2 ** BRIGHT_W);

    // Active-low segment pattern (gfedcba) for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0]        r_slot;
    logic [IDX_W-1:0]        r_idx;

    logic [4*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_en;
    logic                    r_pend_lz;
    logic [BRIGHT_W-1:0]     r_pend_bright;
    logic                    r_pending;

    logic [4*NUM_DIGITS-1:0] r_act_value;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_en;
    logic                    r_act_lz;
    logic [BRIGHT_W-1:0]     r_act_bright;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_slot_last;
    logic                    w_idx_last;
    logic                    w_boundary;
    logic [31:0]             w_on_len;
    logic                    w_on;
    logic                    w_drive;
    logic                    w_supp;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_seg;
    logic                    w_dp;

    // Scan timing, drive window and next output pattern from the current counter state.
    always_comb begin
        logic v_acc;
        w_slot_last = (r_slot == CNT_W'(DIGIT_CYCLES - 1));
        w_idx_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));
        w_boundary  = w_slot_last && w_idx_last;
        w_on_len    = STEP * (32'(r_act_bright) + 32'd1);
        w_on        = (32'(r_slot) >= 32'(BLANK_CYCLES)) &&
                      (32'(r_slot) < (32'(BLANK_CYCLES) + w_on_len));
        // w_upper_zero[i] = nibbles i..NUM_DIGITS-1 are all zero.
        v_acc = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_acc           = v_acc && (r_act_value[4*i +: 4] == 4'h0);
            w_upper_zero[i] = v_acc;
        end
        w_nib   = r_act_value[{r_idx, 2'b00} +: 4];
        w_drive = w_on && r_act_en[r_idx];
        w_supp  = r_act_lz && (r_idx != IDX_W'(0)) && w_upper_zero[r_idx];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an[i] = !(w_drive && (r_idx == IDX_W'(i)));
        end
        if (w_drive && !w_supp) begin
            w_seg = seg_decode(w_nib);
        end else begin
            w_seg = 7'h7F;
        end
        w_dp = !(w_drive && r_act_dp[r_idx]);
    end

    // Slot counter and digit index; the slot length never depends on enables.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot <= CNT_W'(0);
            r_idx  <= IDX_W'(0);
        end else if (w_slot_last) begin
            r_slot <= CNT_W'(0);
            r_idx  <= w_idx_last ? IDX_W'(0) : (r_idx + IDX_W'(1));
        end else begin
            r_slot <= r_slot + CNT_W'(1);
        end
    end

    // Double buffer: load fills pending; the frame boundary promotes it to active.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_value  <= '0;
            r_pend_dp     <= '0;
            r_pend_en     <= '0;
            r_pend_lz     <= 1'b0;
            r_pend_bright <= '0;
            r_pending     <= 1'b0;
            r_act_value   <= '0;
            r_act_dp      <= '0;
            r_act_en      <= '0;
            r_act_lz      <= 1'b0;
            r_act_bright  <= '0;
        end else begin
            if (i_load) begin
                r_pend_value  <= i_value;
                r_pend_dp     <= i_dp_in;
                r_pend_en     <= i_digit_en;
                r_pend_lz     <= i_lz_blank;
                r_pend_bright <= i_brightness;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                // A load on the boundary cycle bypasses the pending buffer.
                if (i_load) begin
                    r_act_value  <= i_value;
                    r_act_dp     <= i_dp_in;
                    r_act_en     <= i_digit_en;
                    r_act_lz     <= i_lz_blank;
                    r_act_bright <= i_brightness;
                end else if (r_pending) begin
                    r_act_value  <= r_pend_value;
                    r_act_dp     <= r_pend_dp;
                    r_act_en     <= r_pend_en;
                    r_act_lz     <= r_pend_lz;
                    r_act_bright <= r_pend_bright;
                end
            end else if (i_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Registered pin drive, one cycle behind the counter state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= w_boundary;
        end
    end

    assign o_an         = r_an;
    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_frame_done = r_frame_done;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with small parameters. A cycle-level
// reference model, built from elapsed time since reset, predicts every output
// on every cycle. Directed steps follow the test plan, and a randomized load
// phase follows them.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DC    = 32;
    localparam int BC    = 16;
    localparam int BW    = 2;
    localparam int FRAME = ND * DC;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [15:0]   i_value;
    logic [3:0]    i_dp_in;
    logic [3:0]    i_digit_en;
    logic          i_lz_blank;
    logic [1:0]    i_brightness;
    logic          i_load;
    logic          o_pending;
    logic          o_frame_done;
    logic [6:0]    o_seg;
    logic          o_dp;
    logic [3:0]    o_an;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: elapsed cycles since reset plus both buffers.
    int          m_t;
    logic [15:0] m_av, m_pv;
    logic [3:0]  m_adp, m_pdp, m_aen, m_pen;
    logic        m_alz, m_plz;
    logic [1:0]  m_ab, m_pb;
    logic        m_pending;

    always #5 i_clk = ~i_clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC),
        .BRIGHT_W    (BW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_value     (i_value),
        .i_dp_in     (i_dp_in),
        .i_digit_en  (i_digit_en),
        .i_lz_blank  (i_lz_blank),
        .i_brightness(i_brightness),
        .i_load      (i_load),
        .o_pending   (o_pending),
        .o_frame_done(o_frame_done),
        .o_seg       (o_seg),
        .o_dp        (o_dp),
        .o_an        (o_an)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_t = 0;
        m_av = '0; m_adp = '0; m_aen = '0; m_alz = 1'b0; m_ab = '0;
        m_pv = '0; m_pdp = '0; m_pen = '0; m_plz = 1'b0; m_pb = '0;
        m_pending = 1'b0;
    endtask

    // One clock: predict the outputs from the pre-edge time and the active buffer, advance the model, compare.
    task automatic tick();
        int         slot, dig, onl;
        logic       bnd, e_dp, e_pend;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        slot  = m_t % DC;
        dig   = (m_t / DC) % ND;
        bnd   = (slot == DC - 1) && (dig == ND - 1);
        onl   = ((DC - BC) / (1 << BW)) * (int'(m_ab) + 1);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (slot >= BC && slot < BC + onl && m_aen[dig]) begin
            e_an[dig] = 1'b0;
            if (m_alz && dig > 0 && (m_av >> (4 * dig)) == 16'h0)
                e_seg = 7'h7F;
            else
                e_seg = SEG_TAB[(m_av >> (4 * dig)) & 16'hF];
            e_dp = !m_adp[dig];
        end
        e_pend = bnd ? 1'b0 : (i_load ? 1'b1 : m_pending);
        @(posedge i_clk);
        if (bnd) begin
            if (i_load) begin
                m_av = i_value; m_adp = i_dp_in; m_aen = i_digit_en;
                m_alz = i_lz_blank; m_ab = i_brightness;
            end else if (m_pending) begin
                m_av = m_pv; m_adp = m_pdp; m_aen = m_pen; m_alz = m_plz; m_ab = m_pb;
            end
        end
        if (i_load) begin
            m_pv = i_value; m_pdp = i_dp_in; m_pen = i_digit_en;
            m_plz = i_lz_blank; m_pb = i_brightness;
        end
        m_pending = e_pend;
        m_t++;
        #1;
        chk("an", 32'(o_an), 32'(e_an));
        chk("seg", 32'(o_seg), 32'(e_seg));
        chk("dp", 32'(o_dp), 32'(e_dp));
        chk("frame_done", 32'(o_frame_done), 32'(bnd));
        chk("pending", 32'(o_pending), 32'(e_pend));
    endtask

    task automatic load_cfg(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] en,
                            input logic lz, input logic [1:0] br);
        i_value = v; i_dp_in = dpi; i_digit_en = en; i_lz_blank = lz; i_brightness = br;
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
    endtask

    // Advance until the model's pre-edge frame position equals pos (at most one frame).
    task automatic run_to(input int pos);
        while (m_t % FRAME != pos) tick();
    endtask

    task automatic count_an(input logic [3:0] pat, output int cnt);
        cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (o_an == pat) cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic [15:0] rv;
        i_rst = 1'b1; i_value = '0; i_dp_in = '0; i_digit_en = '0;
        i_lz_blank = 1'b0; i_brightness = '0; i_load = 1'b0;
        #2;
        chk("rst_an", 32'(o_an), 32'hF);
        chk("rst_seg", 32'(o_seg), 32'h7F);
        repeat (3) @(posedge i_clk);
        #1;
        model_reset();
        i_rst = 1'b0;

        // Dark after reset for two frames, with one frame_done per frame.
        cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (o_frame_done) cnt++;
        end
        chk("fd_count", 32'(cnt), 32'd2);

        // Full brightness on 12AF: digits show 0E, 08, 24, 79.
        load_cfg(16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3);
        chk("pend_after_load", 32'(o_pending), 32'd1);
        run_to(0);
        run_to(16);
        tick();
        chk("d0_an", 32'(o_an), 32'hE);
        chk("d0_seg", 32'(o_seg), 32'h0E);
        run_to(DC + 16);
        tick();
        chk("d1_seg", 32'(o_seg), 32'h08);
        run_to(3 * DC + 16);
        tick();
        chk("d3_seg", 32'(o_seg), 32'h79);

        // Brightness 0 gives 4 lit cycles per slot; brightness 1 gives 8.
        load_cfg(16'h12AF, 4'h0, 4'hF, 1'b0, 2'd0);
        run_to(0);
        count_an(4'hE, cnt);
        chk("bright0_len", 32'(cnt), 32'd4);
        load_cfg(16'h12AF, 4'h0, 4'hF, 1'b0, 2'd1);
        run_to(0);
        count_an(4'hE, cnt);
        chk("bright1_len", 32'(cnt), 32'd8);

        // Leading-zero suppression on 0050 with dp on digit 1.
        load_cfg(16'h0050, 4'b0010, 4'hF, 1'b1, 2'd3);
        run_to(0);
        run_to(16);
        tick();
        chk("lz_d0_seg", 32'(o_seg), 32'h40);
        run_to(DC + 16);
        tick();
        chk("lz_d1_seg", 32'(o_seg), 32'h12);
        chk("lz_d1_dp", 32'(o_dp), 32'd0);
        run_to(2 * DC + 16);
        tick();
        chk("lz_d2_an", 32'(o_an), 32'hB);
        chk("lz_d2_seg", 32'(o_seg), 32'h7F);
        run_to(3 * DC + 16);
        tick();
        chk("lz_d3_an", 32'(o_an), 32'h7);
        chk("lz_d3_dp", 32'(o_dp), 32'd1);

        // A mid-frame load waits for the boundary.
        run_to(40);
        load_cfg(16'hFFFF, 4'h0, 4'hF, 1'b0, 2'd3);
        chk("mid_pending", 32'(o_pending), 32'd1);
        run_to(DC + 16);
        tick();
        chk("mid_unchanged", 32'(o_seg), 32'h12);
        run_to(16);
        tick();
        chk("mid_applied", 32'(o_seg), 32'h0E);
        chk("mid_pend_clr", 32'(o_pending), 32'd0);

        // A load on the boundary cycle is applied at that boundary.
        run_to(FRAME - 1);
        load_cfg(16'h0008, 4'h0, 4'h1, 1'b0, 2'd3);
        chk("bnd_pending", 32'(o_pending), 32'd0);
        run_to(16);
        tick();
        chk("bnd_an", 32'(o_an), 32'hE);
        chk("bnd_seg", 32'(o_seg), 32'h00);

        // Async reset inside an ON window, with pending data to discard.
        load_cfg(16'h1234, 4'hF, 4'hF, 1'b0, 2'd3);
        tick();
        chk("pre_rst_an", 32'(o_an), 32'hE);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_an", 32'(o_an), 32'hF);
        chk("async_seg", 32'(o_seg), 32'h7F);
        chk("async_dp", 32'(o_dp), 32'd1);
        chk("async_pend", 32'(o_pending), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        i_rst = 1'b0;
        repeat (2 * FRAME) tick();

        // Randomized loads, including bursts and leading-zero-heavy values.
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                rv = 16'($urandom) >> $urandom_range(0, 15);
                load_cfg(rv, 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
